// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM state
// encodings and the alignment helper used by the optional misalign trap.
package mem_access_unit_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;   // 2'b11 is also decoded as word

   typedef enum logic [1:0] {
      MAU_IDLE   = 2'b00,
      MAU_ACCESS = 2'b01,
      MAU_RESP   = 2'b10
   } mau_state_e;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = addr_lo[0];
         default:   mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory port with a req/ack handshake.
//   master: the load/store unit (drives request, address, byte enables, data)
//   slave : the memory (returns ack and read data in the same cycle)
interface mem_access_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_access_unit_lane_fmt.sv
// mau_lane_fmt: combinational byte-lane formatting, shared by the store and
// load paths of the load/store unit.
//   size, addr_lo, sign_ext : latched access attributes
//   wdata                   : LSB-justified store data
//   rdata                   : captured memory read word
//   be                      : byte-lane enables
//   wdata_rep               : store data replicated across lanes
//   rdata_fmt               : lane-selected, zero/sign-extended load result
module mau_lane_fmt
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_fmt
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel  = 8'(rdata >> {addr_lo, 3'b000});
      half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      be        = 4'b1111;
      wdata_rep = wdata;
      rdata_fmt = rdata;
      case (size)
         SIZE_BYTE: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_fmt = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         end
         SIZE_HALF: begin
            // addr_lo[0] is ignored: a halfword always lands on a lane pair
            be        = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
            rdata_fmt = {{16{sign_ext & half_sel[15]}}, half_sel};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            rdata_fmt = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage behind the decoder. Accepts one access at
// a time, runs it on the data-memory port with a bounded ack wait, and
// returns the formatted load result with a one-cycle resp_valid pulse.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   mem               data-memory port (master side)
//   req_valid, rd_en, wr_en, size, sign_ext, addr, wdata   request
//   req_ready, stall  idle / access-in-flight indications
//   resp_valid, resp_data, bus_err                          response
//   misalign_err      only with MEM_ACCESS_MISALIGN_TRAP_EN defined
//
// Build option: MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned half/word
// accesses without a memory cycle. Without it, low address bits are simply
// ignored for the lane choice.
//
// state      | meaning
// MAU_IDLE   | ready for a request
// MAU_ACCESS | mem_req held, waiting for mem_ack or timeout
// MAU_RESP   | one-cycle response pulse
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   mem_access_unit_if.master mem,
   input  logic        req_valid,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        req_ready,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        bus_err
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   ,
   output logic        misalign_err
`endif
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mau_state_e state_q, state_d;

   logic [31:0]      addr_q;
   logic [1:0]       size_q;
   logic             sext_q;
   logic             we_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   logic             accept;
   logic             timeout;
   logic             in_access;
   logic             resp_ok;

   logic [3:0]       be;
   logic [31:0]      wdata_rep;
   logic [31:0]      rdata_fmt;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   logic             mis_d;
   logic             mis_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= MAU_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      timeout = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      mis_d   = 1'b0;
`endif
      case (state_q)
         MAU_IDLE: begin
            if (req_valid && (rd_en || wr_en)) begin
               accept  = 1'b1;
               state_d = MAU_ACCESS;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
               if (is_misaligned(size, addr[1:0])) begin
                  mis_d   = 1'b1;
                  state_d = MAU_RESP;
               end
`endif
            end
         end
         MAU_ACCESS: begin
            // an ack in the final wait cycle still completes normally
            if (mem.mem_ack) begin
               state_d = MAU_RESP;
            end else if (cnt_q == CNT_LAST) begin
               timeout = 1'b1;
               state_d = MAU_RESP;
            end
         end
         MAU_RESP: state_d = MAU_IDLE;
         default:  state_d = MAU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         size_q  <= SIZE_BYTE;
         sext_q  <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            MAU_IDLE: begin
               if (accept) begin
                  addr_q  <= addr;
                  size_q  <= size;
                  sext_q  <= sign_ext;
                  we_q    <= wr_en;      // store wins when both enables are set
                  wdata_q <= wdata;
                  rdata_q <= '0;
                  err_q   <= 1'b0;
                  cnt_q   <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                  mis_q   <= mis_d;
`endif
               end
            end
            MAU_ACCESS: begin
               cnt_q <= cnt_q + 1'b1;
               if (mem.mem_ack) rdata_q <= mem.mem_rdata;
               else if (timeout) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   mau_lane_fmt u_lane_fmt (
      .size      (size_q),
      .addr_lo   (addr_q[1:0]),
      .sign_ext  (sext_q),
      .wdata     (wdata_q),
      .rdata     (rdata_q),
      .be        (be),
      .wdata_rep (wdata_rep),
      .rdata_fmt (rdata_fmt)
   );

   assign in_access     = (state_q == MAU_ACCESS);
   assign mem.mem_req   = in_access;
   assign mem.mem_we    = in_access & we_q;
   assign mem.mem_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
   assign mem.mem_be    = in_access ? be : 4'h0;
   assign mem.mem_wdata = in_access ? wdata_rep : 32'h0;

   assign req_ready  = (state_q == MAU_IDLE);
   assign stall      = (state_q == MAU_ACCESS) || (state_q == MAU_RESP);
   assign resp_valid = (state_q == MAU_RESP);
   assign bus_err    = resp_valid & err_q;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign misalign_err = resp_valid & mis_q;
   assign resp_ok      = !we_q && !err_q && !mis_q;
`else
   assign resp_ok      = !we_q && !err_q;
`endif

   assign resp_data = (resp_valid && resp_ok) ? rdata_fmt : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int TB_TIMEOUT = 16;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sign_ext = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        req_ready;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        bus_err;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   logic        misalign_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   exp_t exp_q[$];

   mem_access_unit_if mem_bus ();

   mem_access_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem        (mem_bus),
      .req_valid  (req_valid),
      .rd_en      (rd_en),
      .wr_en      (wr_en),
      .size       (size),
      .sign_ext   (sign_ext),
      .addr       (addr),
      .wdata      (wdata),
      .req_ready  (req_ready),
      .stall      (stall),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .bus_err    (bus_err)
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      ,
      .misalign_err (misalign_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // response scoreboard: every resp_valid pulse must match the oldest expectation
   always @(negedge clk) begin
      if (resp_valid) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_resp", 32'(resp_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("resp_data", resp_data, e.data);
            check_val("bus_err", 32'(bus_err), 32'(e.err));
            check_val("resp_stall", 32'(stall), 32'd1);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            check_val("misalign_err", 32'(misalign_err), 32'(e.mis));
`endif
         end
      end
   end

   // ack_lat: ACCESS cycle (1-based) in which mem_ack is raised; 0 = never
   task automatic run_access(input string tag, input logic rd, input logic wr,
                             input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ack_lat, input logic [31:0] rdat,
                             input logic exp_we, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata,
                             input logic [31:0] exp_data, input logic exp_err);
      int req_cycles;
      int exp_cycles;
      @(negedge clk);
      check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; rd_en = rd; wr_en = wr; size = sz; sign_ext = sx;
      addr = a; wdata = wd;
      exp_q.push_back('{data: exp_data, err: exp_err, mis: 1'b0});
      @(posedge clk); #1;
      req_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = $urandom; wdata = $urandom;
      check_val({tag, "_addr"},  mem_bus.mem_addr, {a[31:2], 2'b00});
      check_val({tag, "_be"},    32'(mem_bus.mem_be), 32'(exp_be));
      check_val({tag, "_we"},    32'(mem_bus.mem_we), 32'(exp_we));
      if (exp_we) check_val({tag, "_wdata"}, mem_bus.mem_wdata, exp_wdata);
      check_val({tag, "_stall"}, 32'(stall), 32'd1);
      req_cycles = 0;
      for (int c = 1; c <= 40; c++) begin
         if (!mem_bus.mem_req) break;
         req_cycles++;
         if (c == ack_lat) begin
            mem_bus.mem_ack = 1'b1;
            mem_bus.mem_rdata = rdat;
         end
         @(posedge clk); #1;
         mem_bus.mem_ack = 1'b0;
         mem_bus.mem_rdata = $urandom;
      end
      exp_cycles = (ack_lat > 0) ? ack_lat : TB_TIMEOUT;
      check_val({tag, "_req_cycles"}, 32'(req_cycles), 32'(exp_cycles));
      repeat (3) @(posedge clk);
      #1;
      check_val({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      mem_bus.mem_ack = 1'b0;
      mem_bus.mem_rdata = '0;
      #23;
      check_val("rst_ready", 32'(req_ready), 32'd1);
      check_val("rst_stall", 32'(stall), 32'd0);
      check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_val("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
      check_val("rst_bus_err", 32'(bus_err), 32'd0);
      check_val("rst_resp_data", resp_data, 32'd0);
      @(negedge clk); rst = 1'b1;
      repeat (2) @(posedge clk);

      //          tag     rd    wr    size       sx    addr          wdata         ack rdata         we    be     wdata_rep     resp_data     err
      run_access("lw",   1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0000_0100, 32'h0,        2, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'h0,        32'hDEAD_BEEF, 1'b0);
      run_access("lb",   1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h0000_0103, 32'h0,        1, 32'h8012_3456, 1'b0, 4'h8, 32'h0,        32'hFFFF_FF80, 1'b0);
      run_access("lbu",  1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h0000_0103, 32'h0,        3, 32'h8012_3456, 1'b0, 4'h8, 32'h0,        32'h0000_0080, 1'b0);
      run_access("lbp",  1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h0000_0101, 32'h0,        1, 32'h0000_7F00, 1'b0, 4'h2, 32'h0,        32'h0000_007F, 1'b0);
      run_access("lh",   1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h0000_0102, 32'h0,        2, 32'h8001_1234, 1'b0, 4'hC, 32'h0,        32'hFFFF_8001, 1'b0);
      run_access("lhu",  1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h0000_0100, 32'h0,        1, 32'h1234_8765, 1'b0, 4'h3, 32'h0,        32'h0000_8765, 1'b0);
      run_access("sh",   1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 2, 32'hFFFF_FFFF, 1'b1, 4'hC, 32'hABCD_ABCD, 32'h0,        1'b0);
      run_access("sb",   1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h0000_0301, 32'h1234_5678, 1, 32'hFFFF_FFFF, 1'b1, 4'h2, 32'h7878_7878, 32'h0,        1'b0);
      run_access("sw_rw",1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 4, 32'hFFFF_FFFF, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0,        1'b0);
      run_access("lw11", 1'b1, 1'b0, 2'b11,     1'b0, 32'h0000_0040, 32'h0,        1, 32'h0BAD_F00D, 1'b0, 4'hF, 32'h0,        32'h0BAD_F00D, 1'b0);
      run_access("tmo",  1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0000_0500, 32'h0,        0, 32'h0,        1'b0, 4'hF, 32'h0,        32'h0,        1'b1);
      run_access("ack16",1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0000_0600, 32'h0,       16, 32'h1357_9BDF, 1'b0, 4'hF, 32'h0,        32'h1357_9BDF, 1'b0);
`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
      run_access("lh_odd",1'b1,1'b0, SIZE_HALF, 1'b0, 32'h0000_0101, 32'h0,        1, 32'hAAAA_5555, 1'b0, 4'h3, 32'h0,        32'h0000_5555, 1'b0);
      run_access("lw_odd",1'b1,1'b0, SIZE_WORD, 1'b0, 32'h0000_0107, 32'h0,        1, 32'h2468_ACE0, 1'b0, 4'hF, 32'h0,        32'h2468_ACE0, 1'b0);
`else
      @(negedge clk);
      req_valid = 1'b1; rd_en = 1'b1; size = SIZE_WORD; sign_ext = 1'b0; addr = 32'h0000_0101;
      exp_q.push_back('{data: 32'h0, err: 1'b0, mis: 1'b1});
      @(posedge clk); #1;
      req_valid = 1'b0; rd_en = 1'b0;
      check_val("mis_resp_valid", 32'(resp_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check_val("mis_mem_req", 32'(mem_bus.mem_req), 32'd0);
         @(posedge clk); #1;
      end
      check_val("mis_drained", 32'(exp_q.size()), 32'd0);
`endif

      // request with neither enable, and a stray ack while idle: both ignored
      @(negedge clk);
      req_valid = 1'b1; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_bus.mem_ack = 1'b0;
      check_val("noen_ready", 32'(req_ready), 32'd1);
      check_val("noen_mem_req", 32'(mem_bus.mem_req), 32'd0);
      repeat (3) @(posedge clk);

      // reset while the memory access is outstanding
      @(negedge clk);
      req_valid = 1'b1; rd_en = 1'b1; size = SIZE_WORD; addr = 32'h0000_0700;
      @(posedge clk); #1;
      req_valid = 1'b0; rd_en = 1'b0;
      check_val("rstmid_req_before", 32'(mem_bus.mem_req), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check_val("rstmid_req_drop", 32'(mem_bus.mem_req), 32'd0);
      check_val("rstmid_stall", 32'(stall), 32'd0);
      @(negedge clk); rst = 1'b1;
      repeat (TB_TIMEOUT + 4) @(posedge clk);
      #1;
      check_val("rstmid_ready", 32'(req_ready), 32'd1);
      check_val("rstmid_no_resp", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
